// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared constants and bank state encoding for the UDP transmit payload buffer
package udp_tx_pkg;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;
  localparam logic [15:0] IP_HDR_LEN = 16'd20;
  localparam int BANK_WORDS = 256;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, SENDING} bank_state_e;
endpackage

// File: rtl/tx_bank_ram.sv
// tx_bank_ram: 512x32 simple dual-port RAM with registered read, zero on disabled read
module tx_bank_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [8:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [8:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [512];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= 32'd0;
    else rdata <= re ? mem[raddr] : 32'd0;
  end
endmodule

// File: rtl/udp_tx_payload_buffer.sv
// udp_tx_payload_buffer: packs a byte stream into ping-pong RAM banks and hands packets to the transmitter
module udp_tx_payload_buffer
  import udp_tx_pkg::*;
#(
  parameter int PKT_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        pkt_valid,
  input  logic        pkt_take,
  input  logic        pkt_done,
  input  logic [8:0]  ram_rd_addr,
  output logic [31:0] datain,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic [15:0] drop_cnt
);
  bank_state_e [1:0] st, st_n;
  logic [1:0][10:0] len;
  logic wr_bank, send_bank, sb_after;
  logic [10:0] byte_cnt, cnt_inc;
  logic [31:0] word_buf, new_word;
  logic accept, closing, wr_en, done_ok, take_ok, sending_any, has_pkt;
  logic [15:0] len_ext;
  logic rd_en;
  always_comb begin
    s_ready = st[wr_bank] == EMPTY || st[wr_bank] == FILLING;
    accept = s_valid & s_ready;
    cnt_inc = byte_cnt + 11'd1;
    closing = accept & (s_last | cnt_inc == 11'(PKT_BYTES));
    wr_en = accept & (byte_cnt[1:0] == 2'd3 | closing);
    new_word = word_buf | ({24'd0, s_data} << {~byte_cnt[1:0], 3'b000});
    sending_any = st[0] == SENDING || st[1] == SENDING;
    pkt_valid = st[send_bank] == FULL && !sending_any;
    done_ok = pkt_done && st[send_bank] == SENDING;
    sb_after = send_bank ^ done_ok;
    take_ok = pkt_take && st[sb_after] == FULL && (done_ok || !sending_any);
  end
  // done, take and fill-close always touch different banks, so their order here is free
  always_comb begin
    st_n = st;
    if (done_ok) st_n[send_bank] = EMPTY;
    if (take_ok) st_n[sb_after] = SENDING;
    if (accept) st_n[wr_bank] = closing ? FULL : FILLING;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= {EMPTY, EMPTY};
      len <= '0;
      wr_bank <= 1'b0;
      send_bank <= 1'b0;
      byte_cnt <= 11'd0;
      word_buf <= 32'd0;
      drop_cnt <= 16'd0;
    end else begin
      st <= st_n;
      send_bank <= sb_after;
      if (accept) begin
        byte_cnt <= closing ? 11'd0 : cnt_inc;
        word_buf <= wr_en ? 32'd0 : new_word;
        if (closing) begin
          len[wr_bank] <= cnt_inc;
          wr_bank <= ~wr_bank;
        end
      end
      if (s_valid && s_last && !s_ready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  always_comb begin
    has_pkt = st[send_bank] == FULL || st[send_bank] == SENDING;
    len_ext = {5'd0, len[send_bank]};
    tx_data_length = has_pkt ? len_ext + UDP_HDR_LEN : 16'd0;
    tx_total_length = has_pkt ? len_ext + UDP_HDR_LEN + IP_HDR_LEN : 16'd0;
    rd_en = ram_rd_addr != 9'd0 && ram_rd_addr <= 9'(BANK_WORDS);
  end
  tx_bank_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({wr_bank, byte_cnt[9:2]}),
    .wdata (new_word),
    .re    (rd_en),
    .raddr ({send_bank, ram_rd_addr[7:0] - 8'd1}),
    .rdata (datain)
  );
endmodule

// File: tb/tb_udp_tx_payload_buffer.sv
// tb_udp_tx_payload_buffer: randomized bench checking the payload buffer against a packet-FIFO model
module tb_udp_tx_payload_buffer;
  localparam int PKT_BYTES = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_data = 8'd0;
  logic s_valid = 1'b0, s_last = 1'b0, pkt_take = 1'b0, pkt_done = 1'b0;
  logic [8:0] ram_rd_addr = 9'd0;
  logic s_ready, pkt_valid;
  logic [31:0] datain;
  logic [15:0] tx_data_length, tx_total_length, drop_cnt;
  logic [7:0] m_bytes[$], m_cur[$];
  int m_len[$];
  bit m_sending;
  int m_drop;
  int checks = 0, errors = 0;

  udp_tx_payload_buffer #(.PKT_BYTES(PKT_BYTES)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .pkt_valid(pkt_valid), .pkt_take(pkt_take), .pkt_done(pkt_done),
    .ram_rd_addr(ram_rd_addr), .datain(datain), .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model is a FIFO of closed packets (at most two) plus the open one
  task automatic step(input logic v, input logic l, input logic [7:0] d, input logic tk, input logic dn, input logic [8:0] a);
    bit rdy, chk;
    logic [31:0] ed;
    int hl, idx;
    s_valid = v; s_last = l; s_data = d; pkt_take = tk; pkt_done = dn; ram_rd_addr = a;
    hl = m_len.size() > 0 ? m_len[0] : 0;
    rdy = m_len.size() < 2;
    checks += 5;
    if (s_ready !== rdy) begin errors++; $display("FAIL s_ready got %b exp %b t=%0t", s_ready, rdy, $time); end
    if (pkt_valid !== (hl > 0 && !m_sending)) begin errors++; $display("FAIL pkt_valid got %b exp %b t=%0t", pkt_valid, (hl > 0 && !m_sending), $time); end
    if (tx_data_length !== (hl > 0 ? 16'(hl + 8) : 16'd0)) begin errors++; $display("FAIL data_len got %0d exp %0d t=%0t", tx_data_length, hl > 0 ? hl + 8 : 0, $time); end
    if (tx_total_length !== (hl > 0 ? 16'(hl + 28) : 16'd0)) begin errors++; $display("FAIL total_len got %0d exp %0d t=%0t", tx_total_length, hl > 0 ? hl + 28 : 0, $time); end
    if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL drop_cnt got %0d exp %0d t=%0t", drop_cnt, m_drop, $time); end
    chk = 1'b1;
    ed = 32'd0;
    if (a != 9'd0 && a <= 9'd256) begin
      chk = hl > 0 && int'(a) <= (hl + 3) / 4;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * (int'(a) - 1) + j;
        ed = {ed[23:0], idx < hl ? m_bytes[idx] : 8'h00};
      end
    end
    @(posedge clk);
    if (v && l && !rdy && m_drop < 65535) m_drop++;
    if (dn && m_sending) begin
      for (int j = 0; j < m_len[0]; j++) void'(m_bytes.pop_front());
      void'(m_len.pop_front());
      m_sending = 1'b0;
    end
    if (tk && !m_sending && m_len.size() > 0) m_sending = 1'b1;
    if (v && rdy) begin
      m_cur.push_back(d);
      if (l || m_cur.size() == PKT_BYTES) begin
        m_len.push_back(m_cur.size());
        foreach (m_cur[j]) m_bytes.push_back(m_cur[j]);
        m_cur.delete();
      end
    end
    #1;
    if (chk) begin
      checks++;
      if (datain !== ed) begin errors++; $display("FAIL datain addr %0d got %h exp %h t=%0t", a, datain, ed, $time); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'($urandom_range(0, 300)));
  endtask

  task automatic send_pkt(input int n, input bit last, input bit pattern, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      step(1'b1, last && i == n - 1, pattern ? 8'(i) : 8'($urandom), 1'b0, 1'b0, 9'($urandom_range(0, 300)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; pkt_take = 1'b0; pkt_done = 1'b0;
    @(posedge clk);
    #1;
    m_bytes.delete(); m_cur.delete(); m_len.delete(); m_sending = 1'b0; m_drop = 0;
    checks += 2;
    if ({pkt_valid, datain, tx_data_length, tx_total_length, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset outputs got pv=%b d=%h dl=%0d tl=%0d drop=%0d exp all 0", pkt_valid, datain, tx_data_length, tx_total_length, drop_cnt);
    end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset s_ready got %b exp 1", s_ready); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle(3);
  endtask

  task automatic test_full_packet();
    send_pkt(PKT_BYTES, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (pkt_valid !== 1'b1) begin errors++; $display("FAIL full pkt_valid got %b exp 1", pkt_valid); end
    if (tx_data_length !== 16'd1032) begin errors++; $display("FAIL full data_len got %0d exp 1032", tx_data_length); end
    if (tx_total_length !== 16'd1052) begin errors++; $display("FAIL full total_len got %0d exp 1052", tx_total_length); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1);
    checks++;
    if (datain !== 32'h00010203) begin errors++; $display("FAIL full word1 got %h exp 00010203", datain); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd256);
    checks++;
    if (datain !== 32'hFCFDFEFF) begin errors++; $display("FAIL full word256 got %h exp FCFDFEFF", datain); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd257);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd2);
    idle(4);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd3);
    idle(2);
  endtask

  task automatic test_short_packet();
    logic [7:0] b [5];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) step(1'b1, i == 4, b[i], 1'b0, 1'b0, 9'd0);
    checks += 2;
    if (tx_data_length !== 16'd13) begin errors++; $display("FAIL short data_len got %0d exp 13", tx_data_length); end
    if (tx_total_length !== 16'd33) begin errors++; $display("FAIL short total_len got %0d exp 33", tx_total_length); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1);
    checks++;
    if (datain !== 32'hAABBCCDD) begin errors++; $display("FAIL short word1 got %h exp AABBCCDD", datain); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd2);
    checks++;
    if (datain !== 32'hEE000000) begin errors++; $display("FAIL short word2 got %h exp EE000000", datain); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
    idle(2);
  endtask

  task automatic test_ping_pong();
    send_pkt($urandom_range(1, 200), 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1);
    send_pkt($urandom_range(1, 200), 1'b1, 1'b0, 1'b0);
    idle(3);
    checks++;
    if (pkt_valid !== 1'b0) begin errors++; $display("FAIL pingpong pv during send got %b exp 0", pkt_valid); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd1);
    checks++;
    if (pkt_valid !== 1'b1) begin errors++; $display("FAIL pingpong pv after done got %b exp 1", pkt_valid); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd1);
    idle(2);
  endtask

  task automatic test_backpressure();
    send_pkt(8, 1'b1, 1'b0, 1'b0);
    send_pkt(12, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 9'd0);
    checks += 2;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL bp s_ready got %b exp 0", s_ready); end
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp drop_cnt got %0d exp 1", drop_cnt); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd2);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd2);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp s_ready after free got %b exp 1", s_ready); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd3);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd3);
    idle(2);
  endtask

  task automatic test_done_take_same();
    int nb;
    nb = $urandom_range(1, 100);
    send_pkt($urandom_range(1, 100), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd0);
    send_pkt(nb, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'd1);
    checks += 2;
    if (pkt_valid !== 1'b0) begin errors++; $display("FAIL dt pkt_valid got %b exp 0", pkt_valid); end
    if (tx_data_length !== 16'(nb + 8)) begin errors++; $display("FAIL dt data_len got %0d exp %0d", tx_data_length, nb + 8); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd1);
    idle(2);
  endtask

  task automatic test_spurious();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'd0);
    checks += 2;
    if ({pkt_valid, tx_data_length} !== '0) begin errors++; $display("FAIL spurious got pv=%b dl=%0d exp 0", pkt_valid, tx_data_length); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL spurious s_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_mid_reset();
    send_pkt(50, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_pkt(30, 1'b1, 1'b0, 1'b0);
    send_pkt(20, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1);
    do_reset();
    send_pkt(9, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1);
    checks++;
    if (datain !== 32'h00010203) begin errors++; $display("FAIL post-reset word1 got %h exp 00010203", datain); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, 9'($urandom_range(0, 300)));
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_short_packet();
    test_ping_pong();
    test_backpressure();
    test_done_take_same();
    test_spurious();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_payload_buffer.md
Name: udp_tx_payload_buffer

Overview:
- Upstream stage of the GMII UDP transmitter.
- Accepts a byte stream from the acquisition side and packs it big-endian into 32-bit words. Words are stored in a two-bank (ping-pong) 512x32 RAM.
- Presents one complete packet at a time to the transmitter, through its 9-bit word read port and its UDP/IP length inputs.
- One bank is refilled while the other is being sent.

Parameters:
- PKT_BYTES, 1024, payload bytes that auto-close a packet; multiple of 4, range 4..1024.
- BANK_WORDS, 256, words per bank (fixed by the 9-bit read address space).

Ports:
- clk  in  1  transmit clock (GMII tx clock domain)
- rst  in  1  synchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  byte valid
- s_last  in  1  qualifies s_valid; closes the packet early (short packet)
- s_ready  out  1  byte accepted when s_valid & s_ready
- pkt_valid  out  1  a full bank is waiting to be sent
- pkt_take  in  1  pulse: transmitter starts the waiting packet
- pkt_done  in  1  pulse: transmitter finished the CRC; frees the sending bank
- ram_rd_addr  in  9  transmitter word address, payload word n at address n (1-based)
- datain  out  32  registered read data
- tx_data_length  out  16  UDP length = payload bytes + 8
- tx_total_length  out  16  IP total length = payload bytes + 28
- drop_cnt  out  16  count of s_last pulses that closed no packet (see below); saturating

Behaviour:
- Reset: every output is 0, except s_ready = 1 (after reset, with both banks empty). Both banks EMPTY, write bank = 0, packer cleared.
- Reset mid-operation aborts any packet in fill or in send; the transmitter is expected to be reset by the same rst.
- Bank states: EMPTY -> FILLING -> FULL -> SENDING -> EMPTY.
  - EMPTY -> FILLING: on the first accepted byte.
  - FILLING -> FULL: on the byte count reaching PKT_BYTES, or on an accepted byte with s_last = 1.
  - FULL -> SENDING: on pkt_take while pkt_valid = 1.
  - SENDING -> EMPTY: on pkt_done.
- Write side:
  - s_ready = 1 iff the current write bank is EMPTY or FILLING.
  - Byte k of a packet goes to word k/4, lane (3 - k%4); lane 3 = bits [31:24], sent first.
  - A word is written at physical address {bank, k/4} when lane 0 is filled, or when the packet closes. Unfilled lanes of the last word are written as 0.
  - After a bank closes, the write bank toggles. s_ready drops only if the new write bank is not EMPTY.
  - The cycle following a close, bytes may be accepted into the other bank; no dead cycle.
- Per-bank length register: stores the byte count, 1..1024, 11 bits.
  - tx_data_length = count + 16'd8; tx_total_length = count + 16'd28. Zero-extended arithmetic.
  - Outputs drive the value for the bank that is FULL-oldest or SENDING.
  - Outputs are held stable from pkt_take until pkt_done. They read 0 when no bank is FULL/SENDING.
- Send order: strictly FIFO between the banks, tracked with a send-bank pointer.
  - pkt_valid = 1 when the send-bank is FULL and no bank is SENDING.
  - pkt_take while pkt_valid = 0 is ignored.
  - pkt_done while no bank is SENDING is ignored.
  - pkt_done and a fill-close in the same cycle are both applied.
  - pkt_done and pkt_take in the same cycle: done applies first; take then starts the other bank if it is FULL.
- Read side:
  - datain is registered, 1-cycle latency, from RAM address {send_bank, ram_rd_addr - 1}.
  - ram_rd_addr = 0 or > 256 gives datain = 0 on the next cycle.
  - Reads beyond the packet length return stale/zero data and are harmless; the transmitter reads one word past the end.
- drop_cnt: s_last is always accepted with a byte, so it never closes an empty packet. drop_cnt increments only when s_valid & s_last arrive while s_ready = 0, which is an upstream protocol violation. Saturates at 16'hFFFF.

Decomposition:
- Package udp_tx_pkg:
  - constants UDP_HDR_LEN = 8, IP_HDR_LEN = 20, BANK_WORDS = 256
  - bank-state enum {EMPTY, FILLING, FULL, SENDING}
- Sub-module tx_bank_ram: simple dual-port 512x32, one write port, one registered read port, no reset on the array.
- Top level holds the packer, bank FSMs, length registers and pointers.

Test Plan:
1. 1024 bytes 0x00..0xFF repeating, no s_last: pkt_valid rises the cycle after byte 1023. Lengths read 1032/1052. Address 1 gives datain 0x00010203 next cycle; address 256 gives 0xFCFDFEFF.
2. 5 bytes AA BB CC DD EE with s_last on EE: lengths 13/33; word 1 = 0xAABBCCDD, word 2 = 0xEE000000.
3. Ping-pong: fill bank 0, pkt_take, stream a second packet during the send. Second pkt_valid is held low until pkt_done, then rises the next cycle. s_ready never drops.
4. Back-pressure: fill both banks with no take. s_ready = 0; an s_valid & s_last byte increments drop_cnt to 1. pkt_take + pkt_done frees bank 0 and s_ready returns to 1.
5. pkt_done and pkt_take in the same cycle, with the other bank FULL: the other bank goes directly to SENDING and the lengths switch to its count. Spurious pkt_take/pkt_done while idle: no state change.
6. rst asserted mid-fill and mid-send: next cycle all outputs are 0, s_ready = 1, pkt_valid = 0. A new packet then lands in bank 0.
